// File: rtl/tt_au_booth_divider_hhrb98_if.sv
// ---------------------------------------------------------------------------
// tt_au_booth_divider_hhrb98_if
// Bundles the TinyTapeout tile pins of the signed 8-bit divider.
//   ena     : tile enable (0 freezes the tile)
//   ui_in   : operand data bus, two's complement
//   uio_in  : [1:0] cmd, [2] rsel, [7:3] unused
//   uo_out  : quotient (rsel=0) or remainder (rsel=1)
//   uio_out : [7] busy, [6] done, [5] dbz, [4] ovf, [3:0] zero
//   uio_oe  : output enables, constant 8'hF0
// master = the side driving the tile inputs, slave = the divider itself.
// ---------------------------------------------------------------------------
interface tt_au_booth_divider_hhrb98_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_au_booth_divider_hhrb98.sv
// ---------------------------------------------------------------------------
// tt_au_booth_divider_hhrb98
// Iterative signed 8-bit divider (restoring, one quotient bit per cycle).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tile pins (ena, ui_in, uio_in, uo_out, uio_out, uio_oe)
// Commands on uio_in[1:0]: 00 nop, 01 load dividend, 10 load divisor,
// 11 start (rising edge of the command only). Quotient truncates toward
// zero, remainder takes the dividend's sign.
// ---------------------------------------------------------------------------
module tt_au_booth_divider_hhrb98 (
  input  logic                              clk,
  input  logic                              rst_n,
  tt_au_booth_divider_hhrb98_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CMD_LOAD_A = 2'b01;
  localparam logic [1:0] CMD_LOAD_B = 2'b10;
  localparam logic [1:0] CMD_START  = 2'b11;

  state_t             r_state;
  state_t             w_next;

  logic signed [7:0]  r_a;
  logic signed [7:0]  r_b;
  logic [7:0]         r_q;
  logic [7:0]         r_r;
  logic [7:0]         r_mag_a;     // dividend magnitude, shifted out MSB first
  logic [7:0]         r_mag_b;
  logic [7:0]         r_part;      // partial remainder
  logic [7:0]         r_mag_q;
  logic [3:0]         r_cnt;
  logic [1:0]         r_prev_cmd;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dbz;
  logic               r_ovf;

  logic [1:0]         w_cmd;
  logic               w_rsel;
  logic               w_accept;
  logic               w_start;
  logic               w_b_zero;
  logic [8:0]         w_shift;
  logic [9:0]         w_trial;
  logic               w_qbit;
  logic               w_busy;
  logic               w_done;
  logic               w_unused_bits;

  function automatic logic [7:0] neg8(input logic [7:0] v);
    return ~v + 8'd1;
  endfunction

  // |-128| comes out as 8'h80, i.e. 128 read as unsigned.
  function automatic logic [7:0] abs8(input logic signed [7:0] v);
    return v[7] ? neg8(v) : v;
  endfunction

  assign w_cmd         = bus.uio_in[1:0];
  assign w_rsel        = bus.uio_in[2];
  assign w_unused_bits = ^bus.uio_in[7:3];

  assign w_accept = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start  = bus.ena && w_accept && (w_cmd == CMD_START) &&
                    (r_prev_cmd != CMD_START);
  assign w_b_zero = (r_b == 8'sd0);

  // Partial remainder is always below |B| <= 128, so the shifted value fits
  // in 9 bits; a 10-bit subtraction exposes the borrow in bit 9.
  assign w_shift = {r_part, r_mag_a[7]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_mag_b};
  assign w_qbit  = ~w_trial[9];

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (bus.ena) begin
      r_state <= w_next;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = w_b_zero ? S_DONE : S_CALC;
      // Counter values 0..7 are the eight division steps; the beat at 8 is a
      // spare cycle that gives the tile its fixed 10-edge start-to-done time.
      S_CALC:         if (r_cnt == 4'd8) w_next = S_FIX;
      S_FIX:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    w_busy      = (r_state == S_CALC) || (r_state == S_FIX);
    w_done      = (r_state == S_DONE);
    bus.uo_out  = w_rsel ? r_r : r_q;
    bus.uio_out = {w_busy, w_done, r_dbz, r_ovf, 4'b0000};
    bus.uio_oe  = 8'hF0;
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_part     <= '0;
      r_mag_q    <= '0;
      r_cnt      <= '0;
      r_prev_cmd <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (bus.ena) begin
      r_prev_cmd <= w_cmd;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_cmd == CMD_LOAD_A) r_a <= bus.ui_in;
          if (w_cmd == CMD_LOAD_B) r_b <= bus.ui_in;
          if (w_start) begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            if (w_b_zero) begin
              r_q   <= 8'hFF;
              r_r   <= r_a;
              r_dbz <= 1'b1;
            end else begin
              r_mag_a  <= abs8(r_a);
              r_mag_b  <= abs8(r_b);
              r_part   <= '0;
              r_mag_q  <= '0;
              r_cnt    <= '0;
              r_sign_q <= r_a[7] ^ r_b[7];
              r_sign_r <= r_a[7];
            end
          end
        end
        S_CALC: begin
          if (r_cnt != 4'd8) begin
            r_part  <= w_qbit ? w_trial[7:0] : w_shift[7:0];
            r_mag_q <= {r_mag_q[6:0], w_qbit};
            r_mag_a <= {r_mag_a[6:0], 1'b0};
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        S_FIX: begin
          // -128 / -1 gives magnitude 128, which lands on 8'h80 naturally.
          r_q   <= r_sign_q ? neg8(r_mag_q) : r_mag_q;
          r_r   <= r_sign_r ? neg8(r_part) : r_part;
          r_ovf <= (r_a == 8'sh80) && (r_b == 8'shFF);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_au_booth_divider_hhrb98.sv
module tb_tt_au_booth_divider_hhrb98;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_au_booth_divider_hhrb98_if bus();

  tt_au_booth_divider_hhrb98 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_a, m_b, m_q, m_r, m_pq, m_pr;
  logic       m_done, m_dbz, m_ovf, m_povf;
  logic [1:0] m_prev, m_cmd;
  int         m_left;

  // Plain signed integer division: SV '/' truncates toward zero.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic ovf);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    iq = sa / sb;
    ir = sa - iq * sb;
    q  = iq[7:0];
    r  = ir[7:0];
    ovf = (a == 8'h80) && (b == 8'hFF);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_pq = 0; m_pr = 0;
      m_done = 0; m_dbz = 0; m_ovf = 0; m_povf = 0;
      m_prev = 0; m_left = 0;
    end else if (bus.ena) begin
      m_cmd = bus.uio_in[1:0];
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_q = m_pq; m_r = m_pr; m_ovf = m_povf;
        end
      end else begin
        if (m_cmd == 2'd1) m_a = bus.ui_in;
        if (m_cmd == 2'd2) m_b = bus.ui_in;
        if (m_cmd == 2'd3 && m_prev != 2'd3) begin
          m_dbz = 0; m_ovf = 0;
          if (m_b == 8'd0) begin
            m_done = 1; m_dbz = 1; m_q = 8'hFF; m_r = m_a;
          end else begin
            m_done = 0;
            ref_div(m_a, m_b, m_pq, m_pr, m_povf);
            m_left = 10;
          end
        end
      end
      m_prev = m_cmd;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("uio_oe", 32'(bus.uio_oe), 32'h0F0);
    chk("uio_out_low", 32'(bus.uio_out[3:0]), 32'h0);
    chk("busy", 32'(bus.uio_out[7]), 32'(m_left != 0));
    chk("done", 32'(bus.uio_out[6]), 32'(m_done));
    if (m_left == 0) begin
      chk("dbz", 32'(bus.uio_out[5]), 32'(m_dbz));
      chk("ovf", 32'(bus.uio_out[4]), 32'(m_ovf));
      chk("result", 32'(bus.uo_out), 32'(bus.uio_in[2] ? m_r : m_q));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc;
    @(posedge clk);
    #1;
    bus.uio_in[2] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(inout int n, input int limit);
    while (bus.uio_out[6] !== 1'b1 && n < limit) begin
      cyc;
      n++;
    end
    chk("done_timeout", 32'(n < limit), 32'h1);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int n);
    bus.uio_in[1:0] = 2'd1; bus.ui_in = a; cyc;
    bus.uio_in[1:0] = 2'd2; bus.ui_in = b; cyc;
    bus.uio_in[1:0] = 2'd3; cyc;
    bus.uio_in[1:0] = 2'd0;
    n = 0;
    wait_done(n, 40);
  endtask

  task automatic pin(input string name, input logic [7:0] q, input logic [7:0] r,
                     input logic [3:0] flags);
    bus.uio_in[2] = 1'b0; #1;
    chk({name, "_q"}, 32'(bus.uo_out), 32'(q));
    bus.uio_in[2] = 1'b1; #1;
    chk({name, "_r"}, 32'(bus.uo_out), 32'(r));
    chk({name, "_flags"}, 32'(bus.uio_out[7:4]), 32'(flags));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ra, rb;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'hA8;   // junk in the ignored bits, cmd=00, rsel=0
    rst_n      = 1'b0;
    #1;
    chk("rst_uo_out", 32'(bus.uo_out), 32'h0);
    chk("rst_uio_out", 32'(bus.uio_out), 32'h0);
    chk("rst_uio_oe", 32'(bus.uio_oe), 32'h0F0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc;

    // 100 / 7 with exact latency
    do_div(8'd100, 8'd7, n);
    chk("lat_100_7", 32'(n), 32'd10);
    pin("d100_7", 8'h0E, 8'h02, 4'b0100);
    do_div(8'h9C, 8'd7, n);
    pin("dm100_7", 8'hF2, 8'hFE, 4'b0100);
    do_div(8'd100, 8'hF9, n);
    pin("d100_m7", 8'hF2, 8'h02, 4'b0100);

    // divide by zero, then recovery
    do_div(8'd5, 8'd0, n);
    chk("lat_dbz", 32'(n), 32'd0);
    pin("dbz", 8'hFF, 8'h05, 4'b0110);
    do_div(8'd5, 8'd3, n);
    pin("after_dbz", 8'h01, 8'h02, 4'b0100);

    // overflow corner and its neighbour
    do_div(8'h80, 8'hFF, n);
    pin("ovf", 8'h80, 8'h00, 4'b0101);
    do_div(8'h80, 8'h01, n);
    pin("m128_1", 8'h80, 8'h00, 4'b0100);

    // load/start attempts while busy are ignored; held start never retriggers
    bus.uio_in[1:0] = 2'd1; bus.ui_in = 8'd100; cyc;
    bus.uio_in[1:0] = 2'd2; bus.ui_in = 8'd7;   cyc;
    bus.uio_in[1:0] = 2'd3; cyc;
    bus.uio_in[1:0] = 2'd0; n = 0;
    cyc; n++;
    cyc; n++;
    bus.uio_in[1:0] = 2'd1; bus.ui_in = 8'd3; cyc; n++;
    bus.uio_in[1:0] = 2'd3; cyc; n++;
    wait_done(n, 40);
    chk("lat_busy_cmds", 32'(n), 32'd10);
    repeat (5) cyc;
    pin("held_start", 8'h0E, 8'h02, 4'b0100);
    bus.uio_in[1:0] = 2'd0; cyc;

    // asynchronous reset in the middle of CALC
    bus.uio_in[1:0] = 2'd1; bus.ui_in = 8'd100; cyc;
    bus.uio_in[1:0] = 2'd2; bus.ui_in = 8'd7;   cyc;
    bus.uio_in[1:0] = 2'd3; cyc;
    bus.uio_in[1:0] = 2'd0;
    repeat (4) cyc;
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_uo", 32'(bus.uo_out), 32'h0);
    chk("midcalc_rst_uio", 32'(bus.uio_out), 32'h0);
    chk("midcalc_rst_oe", 32'(bus.uio_oe), 32'h0F0);
    cyc;
    rst_n = 1'b1;
    cyc;

    // enable stall of 5 cycles mid-CALC
    bus.uio_in[1:0] = 2'd1; bus.ui_in = 8'd100; cyc;
    bus.uio_in[1:0] = 2'd2; bus.ui_in = 8'd7;   cyc;
    bus.uio_in[1:0] = 2'd3; cyc;
    bus.uio_in[1:0] = 2'd0; n = 0;
    repeat (3) begin cyc; n++; end
    bus.ena = 1'b0;
    repeat (5) begin cyc; n++; end
    bus.ena = 1'b1;
    wait_done(n, 60);
    chk("lat_ena_stall", 32'(n), 32'd15);
    pin("ena_stall", 8'h0E, 8'h02, 4'b0100);

    // randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      if ($urandom_range(0, 9) == 0) ra = 8'h80;
      if ($urandom_range(0, 9) == 0) rb = 8'hFF;
      do_div(ra, rb, n);
      chk("rand_lat", 32'(n), (rb == 8'h00) ? 32'd0 : 32'd10);
      repeat ($urandom_range(0, 2)) cyc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
